left_shifter: RTL and testbench
===============================

LEFT_SHIFTER -- requirements
Module: left_shifter

Interface
REQ-001 Parameter W, default 12, data input width; the R and Q outputs are W+1 bits wide.
REQ-002 clk  input  1  single clock; all registers update on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 A  input  W  operand.
REQ-005 R  output  W+1  combinational fixed left-shift-by-one of A.
REQ-006 in_valid  input  1  qualifies A and shamt for the registered path.
REQ-007 shamt  input  4  variable shift amount for the registered path.
REQ-008 out_valid  output  1  Q and ovf hold a valid result.
REQ-009 Q  output  W+1  registered variable left-shift result.
REQ-010 ovf  output  1  a set bit was shifted beyond bit W of Q.

Function
REQ-011 R SHALL equal {A, 1'b0} at all times, with zero latency; it is independent of clk, rst_n and in_valid.
REQ-012 On each rising clk edge with in_valid=1, Q SHALL load (A << shamt) truncated to W+1 bits, and out_valid SHALL be set to 1.
REQ-013 On each rising clk edge with in_valid=0, out_valid SHALL clear to 0, and Q and ovf SHALL hold their values.
REQ-014 Latency from in_valid to out_valid SHALL be exactly 1 cycle; the block SHALL accept a new input every cycle, with no backpressure.
REQ-015 shamt=0 SHALL give Q = {1'b0, A}; vacated low bits SHALL be zero-filled.
REQ-016 If shamt > W, then Q SHALL be 0 and ovf SHALL equal the OR-reduction of A.
REQ-017 ovf SHALL be 1 exactly when any bit of A at index >= W+1-shamt is set; it updates only when Q updates.

Reset
REQ-018 While rst_n=0, Q, ovf and out_valid SHALL be 0, asynchronously and immediately.
REQ-019 An in_valid input presented during reset SHALL be discarded; the first valid result appears one cycle after an in_valid edge sampled with rst_n=1.
REQ-020 Reset SHALL NOT affect R.

Configuration
REQ-021 With macro LEFT_SHIFTER_OVF_EN defined, ovf SHALL behave per REQ-016 and REQ-017.
REQ-022 Without LEFT_SHIFTER_OVF_EN defined, ovf SHALL be tied to 0 and no ovf logic or register SHALL be synthesized; Q behaviour is unchanged.

Structure
REQ-023 A shared package left_shifter_pkg SHALL hold the default width constant (12) and the shamt width constant (4).
REQ-024 The variable shift SHALL be implemented in one sub-module, left_shifter_barrel: a combinational log-stage barrel shifter producing the W+1-bit result and the lost-bits flag.
REQ-025 The top level left_shifter SHALL contain only the R assignment, the output registers and the handshake logic.

Verification
REQ-026 Fixed shift: A=12'hFFF -> R=13'h1FFE; A=12'hAAA -> R=13'h1554; A=12'h333 -> R=13'h0666, each checked 1 ns after the change, with no clock required.
REQ-027 Registered shift: A=12'h001, shamt=12, in_valid=1 for one edge -> next cycle Q=13'h1000, ovf=0, out_valid=1; the following cycle (in_valid=0) out_valid=0.
REQ-028 Overflow: A=12'h801, shamt=2 -> Q=13'h0004, ovf=1 with LEFT_SHIFTER_OVF_EN defined; ovf=0 without it.
REQ-029 Out of range: A=12'h010, shamt=13 -> Q=0, ovf=1; A=0, shamt=15 -> Q=0, ovf=0.
REQ-030 Back-to-back: in_valid held high for 3 cycles with shamt=0, 1, 2 and A=12'h0F0 -> Q=13'h00F0, 13'h01E0, 13'h03C0 on consecutive cycles, with out_valid high throughout.
REQ-031 Reset mid-stream: drive rst_n low between clock edges while out_valid=1 -> Q, ovf and out_valid drop to 0 immediately, and R continues to track A.

Source files
------------

// File: rtl/left_shifter_pkg.sv
// left_shifter_pkg: shared width constants for the left shifter slice
package left_shifter_pkg;
    localparam int DEF_W = 12;
    localparam int SHW = 4;
endpackage

// File: rtl/left_shifter_if.sv
// left_shifter_if: operand/result bundle between a requester and left_shifter
interface left_shifter_if import left_shifter_pkg::*; #(parameter int W = DEF_W) ();
    logic [W-1:0] A;
    logic [SHW-1:0] shamt;
    logic in_valid;
    logic [W:0] R;
    logic out_valid;
    logic [W:0] Q;
    logic ovf;
    modport master (output A, shamt, in_valid, input R, out_valid, Q, ovf);
    modport slave (input A, shamt, in_valid, output R, out_valid, Q, ovf);
endinterface

// File: rtl/left_shifter_barrel.sv
// left_shifter_barrel: log-stage left barrel shift of {1'b0,a}; lost flag only with LEFT_SHIFTER_OVF_EN
module left_shifter_barrel import left_shifter_pkg::*; #(parameter int W = DEF_W) (
    input  logic [W-1:0] a,
    input  logic [SHW-1:0] shamt,
    output logic [W:0] q
`ifdef LEFT_SHIFTER_OVF_EN
    , output logic lost
`endif
);
    localparam int N = W + 1;
    // each stage k shifts by 2**k; bits pushed past the top are OR-ed into lost first
    always_comb begin
        q = {1'b0, a};
`ifdef LEFT_SHIFTER_OVF_EN
        lost = 1'b0;
`endif
        for (int k = 0; k < SHW; k++) begin
`ifdef LEFT_SHIFTER_OVF_EN
            lost = lost | (shamt[k] & ((1 << k) >= N ? |q : |(q >> (N - (1 << k)))));
`endif
            q = shamt[k] ? q << (1 << k) : q;
        end
    end
endmodule

// File: rtl/left_shifter.sv
// left_shifter: combinational R = A<<1 plus registered variable shift Q; ovf needs LEFT_SHIFTER_OVF_EN
module left_shifter import left_shifter_pkg::*; #(parameter int W = DEF_W) (
    input logic clk,
    input logic rst_n,
    left_shifter_if.slave bus
);
    logic [W:0] shifted;
`ifdef LEFT_SHIFTER_OVF_EN
    logic lost;
`endif
    assign bus.R = {bus.A, 1'b0};
    left_shifter_barrel #(.W(W)) u_barrel (
        .a(bus.A),
        .shamt(bus.shamt),
        .q(shifted)
`ifdef LEFT_SHIFTER_OVF_EN
        , .lost(lost)
`endif
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.Q <= '0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) bus.Q <= shifted;
        end
    end
`ifdef LEFT_SHIFTER_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.ovf <= 1'b0;
        else if (bus.in_valid) bus.ovf <= lost;
    end
`else
    assign bus.ovf = 1'b0;
`endif
endmodule

// File: tb/tb_left_shifter.sv
// tb_left_shifter: directed table, corner sequences and random checks against an arithmetic model
module tb_left_shifter;
    localparam int W = 12;
`ifdef LEFT_SHIFTER_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif
    typedef struct {logic [W-1:0] a; logic [3:0] sh; logic [W:0] q; logic o;} vec_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    logic [W:0] exp_q;
    logic exp_o;
    logic exp_v;
    vec_t tbl [9];
    left_shifter_if #(.W(W)) bus ();
    left_shifter #(.W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask
    task automatic check_out(input string name);
        check({name, ".Q"}, 32'(bus.Q), 32'(exp_q));
        check({name, ".ovf"}, 32'(bus.ovf), 32'(exp_o));
        check({name, ".out_valid"}, 32'(bus.out_valid), 32'(exp_v));
    endtask
    // A * 2**shamt in wide arithmetic; anything above bit W is lost
    function automatic void model(input logic [W-1:0] a, input logic [3:0] s, output logic [W:0] q, output logic o);
        longint v;
        v = longint'(a) * (longint'(1) << s);
        q = v[W:0];
        o = OVF_ON && ((v >> (W + 1)) != 0);
    endfunction
    initial begin
        tbl[0] = '{12'h001, 4'd12, 13'h1000, 1'b0};
        tbl[1] = '{12'h801, 4'd2, 13'h0004, 1'b1};
        tbl[2] = '{12'h010, 4'd13, 13'h0000, 1'b1};
        tbl[3] = '{12'h000, 4'd15, 13'h0000, 1'b0};
        tbl[4] = '{12'h0F0, 4'd0, 13'h00F0, 1'b0};
        tbl[5] = '{12'h0F0, 4'd1, 13'h01E0, 1'b0};
        tbl[6] = '{12'h0F0, 4'd2, 13'h03C0, 1'b0};
        tbl[7] = '{12'hFFF, 4'd0, 13'h0FFF, 1'b0};
        tbl[8] = '{12'hFFF, 4'd2, 13'h1FFC, 1'b1};
        bus.in_valid = 1'b0;
        bus.shamt = '0;
        bus.A = 12'hFFF;
        #1 check("r_fff", 32'(bus.R), 32'h1FFE);
        bus.A = 12'hAAA;
        #1 check("r_aaa", 32'(bus.R), 32'h1554);
        bus.A = 12'h333;
        #1 check("r_333", 32'(bus.R), 32'h0666);
        exp_q = '0; exp_o = 1'b0; exp_v = 1'b0;
        check_out("reset");
        bus.in_valid = 1'b1;
        bus.A = 12'h123;
        bus.shamt = 4'd1;
        repeat (2) @(posedge clk);
        #1 check_out("reset_discard");
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1 check_out("first_edge");
        for (int i = 0; i < 9; i++) begin
            bus.A = tbl[i].a;
            bus.shamt = tbl[i].sh;
            bus.in_valid = 1'b1;
            @(posedge clk);
            #1;
            exp_q = tbl[i].q; exp_o = tbl[i].o & OVF_ON; exp_v = 1'b1;
            check_out($sformatf("tbl%0d", i));
            check($sformatf("tbl%0d.R", i), 32'(bus.R), 32'({tbl[i].a, 1'b0}));
        end
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1 exp_v = 1'b0;
        check_out("hold");
        for (int i = 0; i < 300; i++) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.A = W'($urandom);
            bus.shamt = 4'($urandom_range(0, 15));
            @(posedge clk);
            #1;
            if (bus.in_valid) model(bus.A, bus.shamt, exp_q, exp_o);
            exp_v = bus.in_valid;
            check_out($sformatf("rnd%0d", i));
            check($sformatf("rnd%0d.R", i), 32'(bus.R), 32'({bus.A, 1'b0}));
        end
        bus.in_valid = 1'b1;
        bus.A = 12'hFFF;
        bus.shamt = 4'd3;
        @(posedge clk);
        #1;
        model(12'hFFF, 4'd3, exp_q, exp_o);
        exp_v = 1'b1;
        check_out("pre_rst");
        #3 rst_n = 1'b0;
        #1 exp_q = '0; exp_o = 1'b0; exp_v = 1'b0;
        check_out("mid_rst");
        bus.A = 12'h555;
        #1 check("mid_rst.R", 32'(bus.R), 32'h0AAA);
        @(posedge clk);
        #1 check_out("mid_rst_edge");
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1 check_out("post_rst");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
